// File: rtl/csr_trap_sequencer_pkg.sv
// rtl/csr_trap_sequencer_pkg.sv - CSR addresses, mstatus bit indices and trap FSM states
package csr_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_TVAL,
    ST_RMW_STATUS,
    ST_R_TVEC,
    ST_R_EPC,
    ST_RMW_MSTATUS_RET,
    ST_REDIRECT
  } trap_state_t;

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// rtl/csr_trap_sequencer_if.sv - single CSR read/write port between sequencer and csr_regs
interface csr_trap_sequencer_if #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
);
  logic                  we;
  logic [CSR_ADDR_W-1:0] wa;
  logic [XLEN-1:0]       wd;
  logic [CSR_ADDR_W-1:0] ra;
  logic [XLEN-1:0]       rd;

  modport master (output we, output wa, output wd, output ra, input rd);
  modport slave  (input we, input wa, input wd, input ra, output rd);
endinterface

// File: rtl/csr_trap_sequencer_csr_port_arbiter.sv
// rtl/csr_trap_sequencer_csr_port_arbiter.sv - ALU/sequencer mux onto the CSR port and stall generation
module csr_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  seq_sel,
  input  logic                  seq_we,
  input  logic [CSR_ADDR_W-1:0] seq_wa,
  input  logic [XLEN-1:0]       seq_wd,
  input  logic [CSR_ADDR_W-1:0] seq_ra,
  input  logic                  alu_csr_we,
  input  logic [CSR_ADDR_W-1:0] alu_csr_wa,
  input  logic [XLEN-1:0]       alu_csr_wd,
  input  logic [CSR_ADDR_W-1:0] alu_csr_ra,
  output logic [XLEN-1:0]       alu_csr_rd,
  output logic                  alu_stall,
  csr_trap_sequencer_if.master  port
);

  // Sequencer owns the port whenever it is active; writes are suppressed while frozen or in reset.
  always_comb begin
    port.we    = clk_en & ~rst & (seq_sel ? seq_we : alu_csr_we);
    port.wa    = seq_sel ? seq_wa : alu_csr_wa;
    port.wd    = seq_sel ? seq_wd : alu_csr_wd;
    port.ra    = seq_sel ? seq_ra : alu_csr_ra;
    alu_stall  = seq_sel;
    alu_csr_rd = port.rd;
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// rtl/csr_trap_sequencer.sv - trap/MRET sequencer sharing the CSR port with the ALU (option: CSR_TRAP_VECTORED_EN)
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12,
  parameter int CAUSE_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  alu_csr_we,
  input  logic [CSR_ADDR_W-1:0] alu_csr_wa,
  input  logic [XLEN-1:0]       alu_csr_wd,
  input  logic [CSR_ADDR_W-1:0] alu_csr_ra,
  output logic [XLEN-1:0]       alu_csr_rd,
  output logic                  alu_stall,
  csr_trap_sequencer_if.master  csr,
  input  logic                  exc_valid,
  input  logic [CAUSE_W-1:0]    exc_cause,
  input  logic [XLEN-1:0]       exc_pc,
  input  logic [XLEN-1:0]       exc_tval,
  input  logic                  int_pending,
  input  logic [CAUSE_W-1:0]    int_cause,
  input  logic [XLEN-1:0]       next_pc,
  input  logic                  mret_valid,
  input  logic                  pipe_empty,
  output logic                  issue_halt,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  busy
);

  trap_state_t           state, state_nxt;
  logic [CAUSE_W-1:0]    cause_q;
  logic                  irq_q;
  logic                  mret_q;
  logic [XLEN-1:0]       epc_q;
  logic [XLEN-1:0]       tval_q;
  logic [XLEN-1:0]       target_q;
  logic [XLEN-1:0]       tvec_target;
  logic                  seq_we;
  logic [CSR_ADDR_W-1:0] seq_wa;
  logic [XLEN-1:0]       seq_wd;
  logic [CSR_ADDR_W-1:0] seq_ra;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] v;
    v = s;
    v[MSTATUS_MPIE] = s[MSTATUS_MIE];
    v[MSTATUS_MIE] = 1'b0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] ret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] v;
    v = s;
    v[MSTATUS_MIE] = s[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    return v;
  endfunction

  // Trap target from mtvec as currently read; vectored mode only applies to interrupts.
  always_comb begin
    tvec_target = csr.rd & ALIGN_MASK;
`ifdef CSR_TRAP_VECTORED_EN
    if (irq_q && csr.rd[1:0] == 2'b01) begin
      tvec_target = (csr.rd & ALIGN_MASK) + (XLEN'(cause_q) << 2);
    end
`endif
  end

  // State register plus trigger capture and redirect target latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cause_q  <= '0;
      irq_q    <= 1'b0;
      mret_q   <= 1'b0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (exc_valid) begin
          cause_q <= exc_cause;
          irq_q   <= 1'b0;
          mret_q  <= 1'b0;
          epc_q   <= exc_pc;
          tval_q  <= exc_tval;
        end else if (mret_valid) begin
          irq_q   <= 1'b0;
          mret_q  <= 1'b1;
        end else if (int_pending) begin
          cause_q <= int_cause;
          irq_q   <= 1'b1;
          mret_q  <= 1'b0;
          epc_q   <= next_pc;
          tval_q  <= '0;
        end
      end
      if (state == ST_R_TVEC) target_q <= tvec_target;
      if (state == ST_R_EPC)  target_q <= csr.rd;
    end
  end

  // Next-state and per-state CSR port accesses, one access per cycle.
  always_comb begin
    state_nxt = state;
    seq_we    = 1'b0;
    seq_wa    = '0;
    seq_wd    = '0;
    seq_ra    = '0;
    case (state)
      ST_IDLE: begin
        if (exc_valid || mret_valid || int_pending) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty) state_nxt = mret_q ? ST_R_EPC : ST_W_EPC;
      end
      ST_W_EPC: begin
        seq_we    = 1'b1;
        seq_wa    = CSR_ADDR_W'(CSR_MEPC);
        seq_wd    = epc_q & ALIGN_MASK;
        state_nxt = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        seq_we    = 1'b1;
        seq_wa    = CSR_ADDR_W'(CSR_MCAUSE);
        seq_wd    = {irq_q, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
        state_nxt = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        seq_we    = 1'b1;
        seq_wa    = CSR_ADDR_W'(CSR_MTVAL);
        seq_wd    = tval_q;
        state_nxt = ST_RMW_STATUS;
      end
      ST_RMW_STATUS: begin
        seq_we    = 1'b1;
        seq_ra    = CSR_ADDR_W'(CSR_MSTATUS);
        seq_wa    = CSR_ADDR_W'(CSR_MSTATUS);
        seq_wd    = trap_status(csr.rd);
        state_nxt = ST_R_TVEC;
      end
      ST_R_TVEC: begin
        seq_ra    = CSR_ADDR_W'(CSR_MTVEC);
        state_nxt = ST_REDIRECT;
      end
      ST_R_EPC: begin
        seq_ra    = CSR_ADDR_W'(CSR_MEPC);
        state_nxt = ST_RMW_MSTATUS_RET;
      end
      ST_RMW_MSTATUS_RET: begin
        seq_we    = 1'b1;
        seq_ra    = CSR_ADDR_W'(CSR_MSTATUS);
        seq_wa    = CSR_ADDR_W'(CSR_MSTATUS);
        seq_wd    = ret_status(csr.rd);
        state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy           = (state != ST_IDLE);
  assign issue_halt     = busy;
  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = redirect_valid ? target_q : '0;

  csr_port_arbiter #(
    .XLEN       (XLEN),
    .CSR_ADDR_W (CSR_ADDR_W)
  ) u_csr_port_arbiter (
    .rst        (rst),
    .clk_en     (clk_en),
    .seq_sel    (busy),
    .seq_we     (seq_we),
    .seq_wa     (seq_wa),
    .seq_wd     (seq_wd),
    .seq_ra     (seq_ra),
    .alu_csr_we (alu_csr_we),
    .alu_csr_wa (alu_csr_wa),
    .alu_csr_wd (alu_csr_wd),
    .alu_csr_ra (alu_csr_ra),
    .alu_csr_rd (alu_csr_rd),
    .alu_stall  (alu_stall),
    .port       (csr)
  );

  // Trap and return pulses arriving while a sequence is in flight are dropped.
  assert property (@(posedge clk) disable iff (rst) busy |-> !(exc_valid || mret_valid));

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb/tb_csr_trap_sequencer.sv - self-checking bench for csr_trap_sequencer
module tb_csr_trap_sequencer;

  localparam int XLEN = 32;
  localparam int AW   = 12;
  localparam int CW   = 5;

`ifdef CSR_TRAP_VECTORED_EN
  localparam bit              VEC     = 1'b1;
  localparam logic [31:0]     INT_TGT = 32'h0000_021C;
`else
  localparam bit              VEC     = 1'b0;
  localparam logic [31:0]     INT_TGT = 32'h0000_0200;
`endif

  localparam logic [31:0] MCAUSE0 = 32'h0000_0055;
  localparam logic [31:0] MTVAL0  = 32'h0000_0AAA;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clk_en = 1'b1;
  logic            alu_csr_we = 1'b0;
  logic [AW-1:0]   alu_csr_wa = '0;
  logic [XLEN-1:0] alu_csr_wd = '0;
  logic [AW-1:0]   alu_csr_ra = '0;
  logic [XLEN-1:0] alu_csr_rd;
  logic            alu_stall;
  logic            exc_valid = 1'b0;
  logic [CW-1:0]   exc_cause = '0;
  logic [XLEN-1:0] exc_pc = '0;
  logic [XLEN-1:0] exc_tval = '0;
  logic            int_pending = 1'b0;
  logic [CW-1:0]   int_cause = '0;
  logic [XLEN-1:0] next_pc = '0;
  logic            mret_valid = 1'b0;
  logic            pipe_empty = 1'b1;
  logic            issue_halt;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  always #5 clk = ~clk;

  csr_trap_sequencer_if #(.XLEN(XLEN), .CSR_ADDR_W(AW)) csr_if ();

  csr_trap_sequencer #(.XLEN(XLEN), .CSR_ADDR_W(AW), .CAUSE_W(CW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .alu_csr_we(alu_csr_we), .alu_csr_wa(alu_csr_wa), .alu_csr_wd(alu_csr_wd),
    .alu_csr_ra(alu_csr_ra), .alu_csr_rd(alu_csr_rd), .alu_stall(alu_stall),
    .csr(csr_if),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .int_pending(int_pending), .int_cause(int_cause), .next_pc(next_pc),
    .mret_valid(mret_valid), .pipe_empty(pipe_empty), .issue_halt(issue_halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  // csr_regs stand-in: combinational read, write on the clock edge
  logic [31:0] regs [0:4095];
  assign csr_if.rd = regs[csr_if.ra];
  always @(posedge clk) if (csr_if.we) regs[csr_if.wa] <= csr_if.wd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          kind;   // 0 exception, 1 interrupt, 2 mret
    logic [4:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [31:0] ms0;
    logic [31:0] tvec0;
    logic [31:0] epc0;
    int          drain;
    logic [31:0] exp_epc;
    logic [31:0] exp_cause;
    logic [31:0] exp_tval;
    logic [31:0] exp_ms;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_write(input logic [11:0] a, input logic [31:0] d);
    alu_csr_we = 1'b1;
    alu_csr_wa = a;
    alu_csr_wd = d;
    step();
    alu_csr_we = 1'b0;
  endtask

  task automatic preload(input logic [31:0] ms, input logic [31:0] tvec, input logic [31:0] epc,
                         input logic [31:0] mc, input logic [31:0] mt);
    alu_write(12'h300, ms);
    alu_write(12'h305, tvec);
    alu_write(12'h341, epc);
    alu_write(12'h342, mc);
    alu_write(12'h343, mt);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step();
    end
    check(name, {31'b0, busy}, 32'd0);
  endtask

  // Reference: architectural effect of a trap or MRET on the CSRs and the PC
  task automatic model(input int kind, input logic [4:0] cause, input logic [31:0] pc,
                       input logic [31:0] tval, input logic [31:0] ms, input logic [31:0] tvec,
                       input logic [31:0] epc0, input int drain,
                       output logic [31:0] e_epc, output logic [31:0] e_cause,
                       output logic [31:0] e_tval, output logic [31:0] e_ms,
                       output logic [31:0] e_pc, output int e_lat);
    logic [31:0] mie, mpie, base;
    base = tvec & ~32'd3;
    if (kind == 2) begin
      mpie    = (ms >> 7) & 32'd1;
      e_epc   = epc0;
      e_cause = MCAUSE0;
      e_tval  = MTVAL0;
      e_ms    = (ms & ~32'h88) | 32'h80 | (mpie << 3);
      e_pc    = epc0;
      e_lat   = 4 + drain;
    end else begin
      mie     = (ms >> 3) & 32'd1;
      e_epc   = pc & ~32'd3;
      e_cause = (kind == 1 ? 32'h8000_0000 : 32'h0) + 32'(cause);
      e_tval  = (kind == 1) ? 32'h0 : tval;
      e_ms    = (ms & ~32'h1888) | 32'h1800 | (mie << 7);
      e_pc    = (VEC && kind == 1 && (tvec & 32'd3) == 32'd1) ? base + 32'd4 * 32'(cause) : base;
      e_lat   = 7 + drain;
    end
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int          lat, pulses;
    logic [31:0] rpc;
    preload(v.ms0, v.tvec0, v.epc0, MCAUSE0, MTVAL0);
    exc_cause = v.cause; int_cause = v.cause;
    exc_pc = v.pc; next_pc = v.pc; exc_tval = v.tval;
    exc_valid = (v.kind == 0);
    int_pending = (v.kind == 1);
    mret_valid = (v.kind == 2);
    pipe_empty = (v.drain == 0);
    lat = 0; pulses = 0; rpc = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      exc_valid = 1'b0; int_pending = 1'b0; mret_valid = 1'b0;
      pipe_empty = (n >= v.drain + 1);
      if (busy && !issue_halt) check({tag, " halt"}, {31'b0, issue_halt}, 32'd1);
      if (redirect_valid) begin
        pulses++;
        if (lat == 0) begin lat = n; rpc = redirect_pc; end
      end
      if (n > 1 && !busy) break;
    end
    pipe_empty = 1'b1;
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " redirect_pc"}, rpc, v.exp_pc);
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " idle"}, {30'b0, busy, issue_halt}, 32'd0);
    check({tag, " mepc"}, regs[12'h341], v.exp_epc);
    check({tag, " mcause"}, regs[12'h342], v.exp_cause);
    check({tag, " mtval"}, regs[12'h343], v.exp_tval);
    check({tag, " mstatus"}, regs[12'h300], v.exp_ms);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{0, 5'd2,  32'h100,  32'h13,       32'h8,    32'h200, 32'h0,  0,
               32'h100,  32'h2,         32'h13,       32'h1880, 32'h200, 7};
    tbl[1] = '{1, 5'd7,  32'h44,   32'hDEAD,     32'h8,    32'h201, 32'h0,  3,
               32'h44,   32'h8000_0007, 32'h0,        32'h1880, INT_TGT, 10};
    tbl[2] = '{2, 5'd0,  32'h0,    32'h0,        32'h1880, 32'h200, 32'h44, 0,
               32'h44,   MCAUSE0,       MTVAL0,       32'h1888, 32'h44,  4};
    tbl[3] = '{0, 5'd31, 32'h1003, 32'hFFFF_FFFF, 32'h0,   32'h203, 32'h0,  1,
               32'h1000, 32'h1F,        32'hFFFF_FFFF, 32'h1800, 32'h200, 8};
    tbl[4] = '{2, 5'd0,  32'h0,    32'h0,        32'h0,    32'h200, 32'h88, 2,
               32'h88,   MCAUSE0,       MTVAL0,       32'h80,   32'h88,  6};
    tbl[5] = '{0, 5'd5,  32'h2000, 32'h0,        32'h1888, 32'h201, 32'h0,  0,
               32'h2000, 32'h5,         32'h0,        32'h1880, 32'h200, 7};

    // reset state, with an ALU write request held during reset
    alu_csr_we = 1'b1; alu_csr_wa = 12'h340; alu_csr_wd = 32'h1;
    step(); step();
    check("reset outputs", {26'b0, busy, issue_halt, redirect_valid, alu_stall, csr_if.we, 1'b0}, 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    alu_csr_we = 1'b0;
    rst = 1'b0;
    step();

    // ALU write passthrough in IDLE
    alu_csr_we = 1'b1; alu_csr_wa = 12'h340; alu_csr_wd = 32'hDEAD_BEEF;
    #1;
    check("idle alu we", {31'b0, csr_if.we}, 32'd1);
    check("idle alu wa", 32'(csr_if.wa), 32'h340);
    check("idle alu wd", csr_if.wd, 32'hDEAD_BEEF);
    check("idle alu_stall", {31'b0, alu_stall}, 32'd0);
    step();
    alu_csr_we = 1'b0; alu_csr_ra = 12'h340;
    #1;
    check("idle alu read", alu_csr_rd, 32'hDEAD_BEEF);

    // directed vectors
    for (int i = 0; i < 6; i++) run_case($sformatf("vec%0d", i), tbl[i]);

    // randomized vectors against the reference model
    for (int i = 0; i < 30; i++) begin
      v.kind  = int'($urandom_range(0, 2));
      v.cause = 5'($urandom);
      v.pc    = $urandom;
      v.tval  = $urandom;
      v.ms0   = $urandom;
      v.tvec0 = $urandom;
      v.epc0  = $urandom;
      v.drain = int'($urandom_range(0, 4));
      model(v.kind, v.cause, v.pc, v.tval, v.ms0, v.tvec0, v.epc0, v.drain,
            v.exp_epc, v.exp_cause, v.exp_tval, v.exp_ms, v.exp_pc, v.exp_lat);
      run_case($sformatf("rnd%0d", i), v);
    end

    // reset asserted in the middle of W_CAUSE
    preload(32'h8, 32'h200, 32'h0, MCAUSE0, 32'h1111);
    exc_valid = 1'b1; exc_cause = 5'd9; exc_pc = 32'h400; exc_tval = 32'h77; pipe_empty = 1'b1;
    step();
    exc_valid = 1'b0;
    step(); step();
    check("mid W_CAUSE wa", 32'(csr_if.wa), 32'h342);
    rst = 1'b1;
    #1;
    check("rst abort outputs", {29'b0, busy, csr_if.we, issue_halt}, 32'd0);
    step();
    check("rst next cycle", {29'b0, busy, csr_if.we, issue_halt}, 32'd0);
    rst = 1'b0;
    step(); step(); step();
    check("rst no mtval write", regs[12'h343], 32'h1111);
    check("rst no mstatus write", regs[12'h300], 32'h8);
    check("rst stays idle", {31'b0, busy}, 32'd0);

    // exc and mret together, ALU write on the trigger cycle and during DRAIN
    preload(32'h8, 32'h600, 32'h0, MCAUSE0, MTVAL0);
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 5'd3; exc_pc = 32'h300; exc_tval = 32'h5;
    pipe_empty = 1'b0;
    alu_csr_we = 1'b1; alu_csr_wa = 12'h340; alu_csr_wd = 32'hCAFE_0001;
    #1;
    check("trigger-cycle alu we", {31'b0, csr_if.we}, 32'd1);
    step();
    exc_valid = 1'b0; mret_valid = 1'b0;
    alu_csr_wd = 32'h1234_5678;
    #1;
    check("drain alu_stall", {31'b0, alu_stall}, 32'd1);
    check("drain no alu we", {31'b0, csr_if.we}, 32'd0);
    step();
    check("trigger-cycle write landed", regs[12'h340], 32'hCAFE_0001);
    alu_csr_we = 1'b0; pipe_empty = 1'b1;
    wait_idle("exc+mret finish", 20);
    check("exc wins mcause", regs[12'h342], 32'h3);
    check("exc wins mepc", regs[12'h341], 32'h300);
    check("exc wins mstatus", regs[12'h300], 32'h1880);
    check("drain write dropped", regs[12'h340], 32'hCAFE_0001);

    // clk_en freeze while in REDIRECT, then in IDLE
    preload(32'h80, 32'h200, 32'h500, MCAUSE0, MTVAL0);
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    step(); step(); step();
    check("mret redirect", {31'b0, redirect_valid}, 32'd1);
    clk_en = 1'b0;
    step(); step(); step();
    check("frozen redirect_valid", {31'b0, redirect_valid}, 32'd1);
    check("frozen redirect_pc", redirect_pc, 32'h500);
    clk_en = 1'b1;
    step();
    check("after freeze idle", {30'b0, busy, redirect_valid}, 32'd0);
    step(); step();
    check("no re-pulse", {31'b0, redirect_valid}, 32'd0);
    check("mret mstatus", regs[12'h300], 32'h88);
    clk_en = 1'b0;
    alu_csr_we = 1'b1; alu_csr_wa = 12'h340; alu_csr_wd = 32'h99;
    #1;
    check("clk_en low we", {31'b0, csr_if.we}, 32'd0);
    step();
    alu_csr_we = 1'b0; clk_en = 1'b1;
    check("clk_en low no write", regs[12'h340], 32'hCAFE_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
